// File: rtl/bpsk_pkg.sv
// Shared constants and types for the BPSK transmit path: frame geometry,
// preamble byte and the packet assembler state encoding.
package bpsk_pkg;

  localparam int PACKET_SIZE = 192;
  localparam int PACKET_BYTES = PACKET_SIZE / 8;
  localparam int PAYLOAD_BYTES = PACKET_BYTES - 1;
  localparam logic [7:0] PREAMBLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } asm_state_t;

endpackage

// File: rtl/packet_assembler.sv
// Collects payload bytes into {PREAMBLE, payload} frames, MSB-first, and holds
// each frame until the serializer takes it. Optional idle flush: PACKET_TIMEOUT_EN.
module packet_assembler
  import bpsk_pkg::*;
#(
  parameter int PACKET_SIZE    = bpsk_pkg::PACKET_SIZE,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int PAYLOAD_BYTES = PACKET_SIZE / 8 - 1,
  localparam int CW            = $clog2(PAYLOAD_BYTES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [PACKET_SIZE-1:0] packet_out,
  output logic                   packet_valid,
  input  logic                   packet_taken,
  output asm_state_t             state_dbg,
  output logic [CW-1:0]          count_dbg
);

  localparam int PW = PACKET_SIZE - 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);

  if ((PACKET_SIZE % 8) != 0 || PACKET_SIZE < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("packet_assembler: unsupported PACKET_SIZE/TIMEOUT_CYCLES");
  end

  // Handshake: a byte moves on a posedge where byte_valid && byte_ready; the
  // source holds byte_in stable until then. packet_valid stays high with a
  // frozen packet_out until a cycle with packet_taken high.
  asm_state_t      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic            accept;

  assign byte_ready   = (state_q != FULL);
  assign packet_valid = (state_q == FULL);
  assign packet_out   = {PREAMBLE, payload_q};
  assign accept       = byte_valid && byte_ready;
  assign state_dbg    = state_q;
  assign count_dbg    = count_q;

`ifdef PACKET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    payload_d = payload_q;
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (count_q == CW'(k)) payload_d[PW-1-8*k -: 8] = byte_in;
          end
          count_d = count_q + 1'b1;
          state_d = (count_q == LAST_IDX) ? FULL : FILL;
        end
      end
      FULL: begin
        if (packet_taken) begin
          state_d   = IDLE;
          count_d   = '0;
          payload_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PACKET_TIMEOUT_EN
    // Unwritten bytes are already zero, so a flush only has to change state.
    timer_d = '0;
    if (state_q == FILL && !accept) begin
      if (timer_q == TIMER_LAST) state_d = FULL;
      else timer_d = timer_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      payload_q <= payload_d;
    end
  end

`ifdef PACKET_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else timer_q <= timer_d;
  end
`endif

endmodule
